lsp_stability: RTL
==================

# lsp_stability

Decoder-side LSP stabilizer for the G.729 LSP dequantizer: the read-side counterpart of the encoder's LSP expansion stage. It performs the ITU `Lsp_stability` procedure in place on a 10-entry LSP buffer in shared scratch memory:
- one bubble pass to fix ordering,
- low-limit clamp on buf[0],
- minimum-gap enforcement between neighbours,
- high-limit clamp on buf[9].

All arithmetic goes through the shared `sub`/`L_sub`/`add` operator units, multiplexed by the top level.

## Interface
- BUF_BASE, 11'd0: base address of the LSP buffer; 16-aligned; entry k at {BUF_BASE[10:4], k[3:0]}
- L_LIMIT, 16'd40: lower clamp for buf[0]
- M_LIMIT, 16'd25681: upper clamp for buf[9]
- GAP3, 16'd321: minimum spacing
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  one-cycle request, sampled only in IDLE
- subIn  in  16  result of shared 16-bit sub (subOutA − subOutB, saturating)
- L_subIn  in  32  result of shared L_sub
- addIn  in  16  result of shared 16-bit add
- memIn  in  32  scratch-memory read data; valid the cycle after memReadAddr is driven
- subOutA, subOutB  out  16  operands to sub
- L_subOutA, L_subOutB  out  32  operands to L_sub
- addOutA, addOutB  out  16  operands to add
- memReadAddr  out  11  read address
- memWriteAddr  out  11  write address
- memOut  out  32  write data: 16-bit result, sign-extended
- memWriteEn  out  1  write strobe; one cycle per write
- done  out  1  one-cycle completion pulse

## Operation
- Outputs are combinational from state and registers. Outside the cycle that uses them, every output is 0, including in IDLE and during reset.
- Internal registers: j (4 bit), a, b (16 bit), temp (32 bit). All reset to 0.
- sext(x) means the 16-bit value x sign-extended to 32 bits. Only memIn[15:0] is used.
- IDLE: start=1 → S_RD0. start is ignored in all other states.
- Sort pass, j = 0..8:
  - S_RD0: read entry 0 → S_LD0.
  - S_LD0: a ← memIn[15:0]; j ← 0; read entry 1 → S_CMP.
  - S_RD: read entry j+1 → S_CMP.
  - S_CMP: b ← memIn[15:0]. Drive L_sub(sext(memIn), sext(a)).
    - If L_subIn[31]=1: write memIn[15:0] to entry j → S_SWP.
    - Otherwise: a ← memIn[15:0], then advance.
  - S_SWP: write a to entry j+1; a is unchanged, and the larger value is carried forward. Then advance.
  - Advance: j ← j+1. If the new j = 9 → L_RD, else → S_RD.
- Low clamp:
  - L_RD: read entry 0 → L_CHK.
  - L_CHK: drive sub(memIn[15:0], L_LIMIT).
    - If subIn[15]=1: write L_LIMIT to entry 0 and set a ← L_LIMIT.
    - Otherwise: a ← memIn[15:0].
    - In both cases j ← 0 → G_RD.
- Gap loop, i = j = 0..8:
  - G_RD: read entry j+1 → G_DIF.
  - G_DIF: b ← memIn[15:0]; drive L_sub(sext(memIn), sext(a)); temp ← L_subIn → G_CHK.
  - G_CHK: drive L_sub(temp, sext(GAP3)).
    - If L_subIn[31]=1: drive add(a, GAP3), write addIn to entry j+1, a ← addIn.
    - Otherwise: a ← b.
    - Then j ← j+1. If the new j = 9 → H_CHK, else → G_RD.
- High clamp, H_CHK:
  - a holds the final buf[9]. Drive sub(a, M_LIMIT).
  - If subIn[15]=0 and subIn≠0: write M_LIMIT to entry 9.
  - In both cases done=1 → IDLE.
- A reset mid-operation aborts immediately:
  - no done is issued;
  - memory writes already made stay;
  - the next start restarts the procedure from S_RD0.

## Timing
- Let the start cycle be cycle 0. S_RD0 is cycle 1.
- done is asserted in cycle 49+k, where k is the number of swaps (0..9).
  - That is 2 + 9 S_CMP + 8 S_RD + k S_SWP + 2 low-clamp + 27 gap + 1 H_CHK.
- Memory data is sampled exactly one cycle after its address. The block never reads an entry in the cycle right after writing it; carried values come from a/b.
- At most one memWriteEn per cycle. Writes occur only in S_CMP, S_SWP, L_CHK, G_CHK and H_CHK.
- start may be asserted in the cycle after done; it is accepted.

## Test plan
- buf[k]=1000·(k+1): no memWriteEn at any point; done at cycle 49; buffer unchanged.
- As above but buf[1]=3000, buf[2]=2000: exactly 2 writes (entry 1←2000, entry 2←3000); done at cycle 50.
- buf[0]=10, buf[k]=1000·(k+1) for k≥1: single write, entry 0←40; done at cycle 49.
- buf[k]=1000+10k: gap chain yields buf[k]=1000+321k (buf[9]=3889); 9 writes.
- buf[k]=1000·(k+1), buf[9]=30000: entry 9←25681 written in H_CHK together with done.
- Assert reset asynchronously at cycle 20, release it, then start again with the case-2 data: all outputs are 0 during reset, there is no done from the aborted run, and the rerun result matches case 2.

Source files
------------

// File: rtl/lsp_stability.sv
// lsp_stability: in-place G.729 LSP stabilizer (sort pass, low clamp, gap enforcement, high clamp)
module lsp_stability #(
   parameter logic [10:0] BUF_BASE = 11'd0,
   parameter logic [15:0] L_LIMIT  = 16'd40,
   parameter logic [15:0] M_LIMIT  = 16'd25681,
   parameter logic [15:0] GAP3     = 16'd321
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] subIn,
   input  logic [31:0] L_subIn,
   input  logic [15:0] addIn,
   input  logic [31:0] memIn,
   output logic [15:0] subOutA,
   output logic [15:0] subOutB,
   output logic [31:0] L_subOutA,
   output logic [31:0] L_subOutB,
   output logic [15:0] addOutA,
   output logic [15:0] addOutB,
   output logic [10:0] memReadAddr,
   output logic [10:0] memWriteAddr,
   output logic [31:0] memOut,
   output logic        memWriteEn,
   output logic        done
);

   typedef enum logic [3:0] {
      IDLE, S_RD0, S_LD0, S_RD, S_CMP, S_SWP, L_RD, L_CHK, G_RD, G_DIF, G_CHK, H_CHK
   } state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_j, w_j, w_j1;
   logic [15:0] r_a, r_b, w_a, w_b, w_m;
   logic [31:0] r_temp, w_temp;
   logic        w_unused;

   function automatic logic [10:0] f_addr(input logic [3:0] k);
      return {BUF_BASE[10:4], k};
   endfunction

   function automatic logic [31:0] f_sext(input logic [15:0] x);
      return {{16{x[15]}}, x};
   endfunction

   assign w_m      = memIn[15:0];
   assign w_unused = &{1'b0, memIn[31:16]};
   assign w_j1     = r_j + 4'd1;

   // the add unit is only engaged when the gap check finds the spacing too small
   assign addOutA = (r_state == G_CHK && L_subIn[31]) ? r_a  : '0;
   assign addOutB = (r_state == G_CHK && L_subIn[31]) ? GAP3 : '0;

   // operands for sub/L_sub and the read address depend only on state, registers and memIn
   always_comb begin
      subOutA     = '0;
      subOutB     = '0;
      L_subOutA   = '0;
      L_subOutB   = '0;
      memReadAddr = '0;
      case (r_state)
         S_RD0, L_RD: memReadAddr = f_addr(4'd0);
         S_LD0:       memReadAddr = f_addr(4'd1);
         S_RD, G_RD:  memReadAddr = f_addr(w_j1);
         S_CMP, G_DIF: begin
            L_subOutA = f_sext(w_m);
            L_subOutB = f_sext(r_a);
         end
         L_CHK: begin
            subOutA = w_m;
            subOutB = L_LIMIT;
         end
         G_CHK: begin
            L_subOutA = r_temp;
            L_subOutB = f_sext(GAP3);
         end
         H_CHK: begin
            subOutA = r_a;
            subOutB = M_LIMIT;
         end
         default: ;
      endcase
   end

   // next state, register updates, memory writes and completion pulse
   always_comb begin
      w_next       = r_state;
      w_j          = r_j;
      w_a          = r_a;
      w_b          = r_b;
      w_temp       = r_temp;
      memWriteEn   = 1'b0;
      memWriteAddr = '0;
      memOut       = '0;
      done         = 1'b0;
      case (r_state)
         IDLE:  w_next = start ? S_RD0 : IDLE;
         S_RD0: w_next = S_LD0;
         S_LD0: begin
            w_a    = w_m;
            w_j    = 4'd0;
            w_next = S_CMP;
         end
         S_RD:  w_next = S_CMP;
         S_CMP: begin
            w_b = w_m;
            if (L_subIn[31]) begin
               memWriteEn   = 1'b1;
               memWriteAddr = f_addr(r_j);
               memOut       = f_sext(w_m);
               w_next       = S_SWP;
            end else begin
               w_a    = w_m;
               w_j    = w_j1;
               w_next = (w_j1 == 4'd9) ? L_RD : S_RD;
            end
         end
         S_SWP: begin
            memWriteEn   = 1'b1;
            memWriteAddr = f_addr(w_j1);
            memOut       = f_sext(r_a);
            w_j          = w_j1;
            w_next       = (w_j1 == 4'd9) ? L_RD : S_RD;
         end
         L_RD:  w_next = L_CHK;
         L_CHK: begin
            if (subIn[15]) begin
               memWriteEn   = 1'b1;
               memWriteAddr = f_addr(4'd0);
               memOut       = f_sext(L_LIMIT);
               w_a          = L_LIMIT;
            end else begin
               w_a = w_m;
            end
            w_j    = 4'd0;
            w_next = G_RD;
         end
         G_RD:  w_next = G_DIF;
         G_DIF: begin
            w_b    = w_m;
            w_temp = L_subIn;
            w_next = G_CHK;
         end
         G_CHK: begin
            if (L_subIn[31]) begin
               memWriteEn   = 1'b1;
               memWriteAddr = f_addr(w_j1);
               memOut       = f_sext(addIn);
               w_a          = addIn;
            end else begin
               w_a = r_b;
            end
            w_j    = w_j1;
            w_next = (w_j1 == 4'd9) ? H_CHK : G_RD;
         end
         H_CHK: begin
            if (!subIn[15] && subIn != 16'd0) begin
               memWriteEn   = 1'b1;
               memWriteAddr = f_addr(4'd9);
               memOut       = f_sext(M_LIMIT);
            end
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // state and working registers; reset aborts any run in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_j     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_temp  <= '0;
      end else begin
         r_state <= w_next;
         r_j     <= w_j;
         r_a     <= w_a;
         r_b     <= w_b;
         r_temp  <= w_temp;
      end
   end

endmodule
